// File: rtl/window_stream_writer_if.sv
// Chunk input and aligned memory write bundle for window_stream_writer.
// The slave view belongs to the writer; the master view belongs to whatever feeds it.
interface window_stream_if #(
  parameter int WIDTH_BYTES     = 8,
  parameter int SIZE_BYTES_LOG2 = 15
);
  localparam int CW = $clog2(WIDTH_BYTES) + 1;

  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH_BYTES*8-1:0]   in_data;
  logic [CW-1:0]              in_bytes;
  logic                       in_last;
  logic                       write_enable;
  logic [SIZE_BYTES_LOG2-1:0] write_address;
  logic [WIDTH_BYTES*8-1:0]   write_data;
  logic [SIZE_BYTES_LOG2-1:0] commit_ptr;

  modport slave (
    input  in_valid, in_data, in_bytes, in_last,
    output in_ready, write_enable, write_address, write_data, commit_ptr
  );

  modport master (
    output in_valid, in_data, in_bytes, in_last,
    input  in_ready, write_enable, write_address, write_data, commit_ptr
  );
endinterface

// File: rtl/window_stream_writer.sv
// Packs a variable-size byte stream into aligned words for the history memory
// and publishes a commit pointer for unaligned readers.
//
// state | meaning
// RUN   | accepting chunks; full/partial words written the cycle after acceptance
// FLUSH | one-cycle bubble writing the padded tail left over after a full word
module window_stream_writer #(
  parameter int WIDTH_BYTES     = 8,
  parameter int SIZE_BYTES_LOG2 = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  window_stream_if.slave bus
);
  localparam int AW = $clog2(WIDTH_BYTES);
  localparam int CW = AW + 1;
  localparam int PW = SIZE_BYTES_LOG2 - AW;
  localparam int DW = WIDTH_BYTES * 8;
  localparam int B2 = 2 * WIDTH_BYTES;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [AW-1:0]              cnt_q, cnt_d;
  logic [DW-1:0]              acc_q, acc_d;
  logic [PW-1:0]              wptr_q, wptr_d, wptr_inc;
  logic                       ready_q, ready_d;
  logic                       we_q, we_d;
  logic [SIZE_BYTES_LOG2-1:0] wa_q, wa_d, cp_q, cp_d;
  logic [DW-1:0]              wd_q, wd_d;

  logic                       accept, full;
  logic [CW-1:0]              nb, s, r;
  logic [B2-1:0]              bmask;
  logic [2*DW-1:0]            ins, acc_ext, merged;
  logic [DW-1:0]              rem;

  assign wptr_inc = wptr_q + PW'(1);
  assign accept   = (state_q == RUN) && ready_q && bus.in_valid;

  // Merge the incoming chunk above the held bytes in a two-word window.
  always_comb begin : pack
    nb      = (bus.in_bytes > CW'(WIDTH_BYTES)) ? CW'(WIDTH_BYTES) : bus.in_bytes;
    ins     = {{DW{1'b0}}, bus.in_data} << {cnt_q, 3'b000};
    bmask   = ((B2'(1) << nb) - B2'(1)) << cnt_q;
    acc_ext = {{DW{1'b0}}, acc_q};
    merged  = '0;
    for (int i = 0; i < B2; i++) begin
      if (bmask[i]) merged[i*8 +: 8] = ins[i*8 +: 8];
      else if (i < int'(cnt_q)) merged[i*8 +: 8] = acc_ext[i*8 +: 8];
    end
    s    = CW'(cnt_q) + nb;
    full = (s >= CW'(WIDTH_BYTES));
    rem  = full ? merged[2*DW-1:DW] : merged[DW-1:0];
    r    = full ? (s - CW'(WIDTH_BYTES)) : s;
  end

  always_comb begin : next
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    wptr_d  = wptr_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    cp_d    = cp_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          acc_d = rem;
          cnt_d = r[AW-1:0];
          if (full) begin
            we_d   = 1'b1;
            wa_d   = {wptr_q, {AW{1'b0}}};
            wd_d   = merged[DW-1:0];
            cp_d   = {wptr_inc, {AW{1'b0}}};
            wptr_d = wptr_inc;
            if (bus.in_last && (r != '0)) state_d = FLUSH;
          end else if (bus.in_last && (r != '0)) begin
            we_d   = 1'b1;
            wa_d   = {wptr_q, {AW{1'b0}}};
            wd_d   = rem;
            cp_d   = {wptr_inc, {AW{1'b0}}};
            wptr_d = wptr_inc;
            acc_d  = '0;
            cnt_d  = '0;
          end
        end
      end
      FLUSH: begin
        // Bytes above the tail are already zero, so acc_q is the padded word.
        we_d    = 1'b1;
        wa_d    = {wptr_q, {AW{1'b0}}};
        wd_d    = acc_q;
        cp_d    = {wptr_inc, {AW{1'b0}}};
        wptr_d  = wptr_inc;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      acc_q   <= '0;
      wptr_q  <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      cp_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      wptr_q  <= wptr_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      cp_q    <= cp_d;
    end
  end

  assign bus.in_ready      = ready_q;
  assign bus.write_enable  = we_q;
  assign bus.write_address = wa_q;
  assign bus.write_data    = wd_q;
  assign bus.commit_ptr    = cp_q;
endmodule

// File: tb/tb_window_stream_writer.sv
// Scoreboard bench for window_stream_writer on a 64-byte window so address wrap is reachable.
// A byte-queue model predicts every write (address, data, cycle); the monitor pops and compares.
module tb_window_stream_writer;
  localparam int W   = 8;
  localparam int SBL = 6;
  localparam int WIN = 1 << SBL;

  typedef struct {
    int          addr;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic clk, rst_n;
  int   cyc, n_total, n_bad;
  int   mwptr;
  logic [7:0] pend[$];
  exp_t sb[$];
  exp_t e;

  window_stream_if #(.WIDTH_BYTES(W), .SIZE_BYTES_LOG2(SBL)) bus ();

  window_stream_writer #(.WIDTH_BYTES(W), .SIZE_BYTES_LOG2(SBL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [63:0] word, input int c);
    exp_t x;
    x.addr = (mwptr * W) % WIN;
    x.data = word;
    x.cyc  = c;
    sb.push_back(x);
    mwptr = (mwptr + 1) % (WIN / W);
  endtask

  task automatic model_accept(input logic [63:0] d, input int nb, input bit last, input int c);
    int n, lat;
    logic [63:0] word;
    n   = (nb > W) ? W : nb;
    lat = 1;
    for (int i = 0; i < n; i++) pend.push_back(d[i*8 +: 8]);
    if (pend.size() >= W) begin
      word = '0;
      for (int i = 0; i < W; i++) word[i*8 +: 8] = pend.pop_front();
      push_word(word, c + 1);
      lat = 2;
    end
    if (last && pend.size() > 0) begin
      word = '0;
      for (int i = 0; pend.size() > 0; i++) word[i*8 +: 8] = pend.pop_front();
      push_word(word, c + lat);
    end
  endtask

  task automatic send(input logic [63:0] d, input int nb, input bit last);
    bit ok;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_bytes = 4'(nb);
    bus.in_last  = last;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("ready_timeout", {63'b0, bus.in_ready}, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    model_accept(d, nb, last, cyc);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.write_enable) begin
      if (sb.size() == 0) begin
        check("spurious_we", {63'b0, bus.write_enable}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("wr_addr",   64'(bus.write_address), 64'(e.addr));
        check("wr_data",   bus.write_data, e.data);
        check("wr_commit", 64'(bus.commit_ptr), 64'((e.addr + W) % WIN));
        check("wr_cycle",  64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    int nb;
    bit last;
    cyc = 0; n_total = 0; n_bad = 0; mwptr = 0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_bytes = '0; bus.in_last = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("rst_ready", {63'b0, bus.in_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge", {63'b0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1 check("ready_after_edge", {63'b0, bus.in_ready}, 64'd1);

    // Eight single bytes make one word.
    for (int i = 1; i <= 8; i++) send(64'(i * 8'h11), 1, 1'b0);
    idle(3);
    check("hold_we",   {63'b0, bus.write_enable}, 64'd0);
    check("hold_addr", 64'(bus.write_address), 64'h0);
    check("hold_data", bus.write_data, 64'h8877665544332211);
    check("hold_cp",   64'(bus.commit_ptr), 64'h8);

    // Partial bytes, then a mid-cycle reset that must discard them.
    send(64'hDEADBEEFCAFEF00D, 3, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_we",    {63'b0, bus.write_enable}, 64'd0);
    check("arst_cp",    64'(bus.commit_ptr), 64'd0);
    check("arst_ready", {63'b0, bus.in_ready}, 64'd0);
    check("arst_addr",  64'(bus.write_address), 64'd0);
    check("arst_data",  bus.write_data, 64'd0);
    check("arst_sb",    64'(sb.size()), 64'd0);
    sb.delete(); pend.delete(); mwptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready_rerelease", {63'b0, bus.in_ready}, 64'd1);

    // 5 + 5 + 6 bytes: two words, second straddles beats.
    send(64'h0000000504030201, 5, 1'b0);
    send(64'h0000000A09080706, 5, 1'b0);
    send(64'h0000100F0E0D0C0B, 6, 1'b0);

    // cnt=6 then 4 bytes with last: full word plus flushed tail, one-cycle stall.
    send(64'h0000262524232221, 6, 1'b0);
    send(64'h0000000044332827, 4, 1'b1);
    check("flush_stall", {63'b0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1 check("flush_resume", {63'b0, bus.in_ready}, 64'd1);

    // Zero-byte beats: with last flushes cnt=3 without stall; without last is a no-op.
    send(64'h0000000000535251, 3, 1'b0);
    send(64'hFFFFFFFFFFFFFFFF, 0, 1'b1);
    check("zero_last_nostall", {63'b0, bus.in_ready}, 64'd1);
    send(64'h0000000000000062, 1, 1'b0);
    send(64'hFFFFFFFFFFFFFFFF, 0, 1'b0);
    send(64'h7877767574737271, 8, 1'b0);
    // Oversized byte count clamps to a full word.
    send(64'h8887868584838281, 15, 1'b1);

    // Back-to-back full words to force address and commit wrap.
    for (int i = 0; i < 10; i++) send({8{8'(8'h90 + i)}}, 8, 1'b0);

    for (int i = 0; i < 300; i++) begin
      d    = {$urandom, $urandom};
      nb   = $urandom_range(0, 15);
      last = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) idle(1);
      send(d, nb, last);
    end
    send(64'h0, 0, 1'b1);
    idle(5);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
